// File: rtl/seg_scan_n.sv
`default_nettype none
// ============================================================================
// seg_scan_n : multiplexed 7-segment scan driver (prescaled scan, dp, blank, blink, polarity)
// Revision   : 1.0
// ============================================================================
module seg_scan_n #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 262144,
  parameter int BLINK_TICKS    = 48,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int POS_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  output logic [DIGITS-1:0]     pos,
  output logic [7:0]            seg,
  output logic                  frame
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [PW-1:0] c_presc_last = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] c_idx_first  = IW'(DIGITS - 1);
  localparam logic [BW-1:0] c_blink_last = BW'(BLINK_TICKS - 1);

  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic [BW-1:0]     r_bcnt;
  logic              r_phase;
  logic [DIGITS-1:0] r_pos;
  logic [7:0]        r_seg;
  logic              r_frame;

  logic              w_tick;
  logic [IW-1:0]     w_idx_nxt;
  logic [3:0]        w_nib;
  logic [6:0]        w_glyph;
  logic              w_dark;

  assign w_tick    = en && (r_presc == c_presc_last);
  assign w_idx_nxt = (r_idx == '0) ? c_idx_first : r_idx - 1'b1;
  assign w_nib     = data[4*w_idx_nxt +: 4];
  // The blink phase used is the one in force before this tick's toggle.
  assign w_dark    = blank[w_idx_nxt] | (blink[w_idx_nxt] & r_phase);

  always_comb begin
    w_glyph = 7'h40;
    case (w_nib)
      4'd0:    w_glyph = 7'h3F;
      4'd1:    w_glyph = 7'h06;
      4'd2:    w_glyph = 7'h5B;
      4'd3:    w_glyph = 7'h4F;
      4'd4:    w_glyph = 7'h66;
      4'd5:    w_glyph = 7'h6D;
      4'd6:    w_glyph = 7'h7D;
      4'd7:    w_glyph = 7'h07;
      4'd8:    w_glyph = 7'h7F;
      4'd9:    w_glyph = 7'h6F;
      4'd10:   w_glyph = 7'h01;
      4'd11:   w_glyph = 7'h08;
      default: w_glyph = 7'h40;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_pos   <= '0;
      r_seg   <= 8'h00;
      r_frame <= 1'b0;
    end else if (!en) begin
      r_pos   <= '0;
      r_seg   <= 8'h00;
      r_frame <= 1'b0;
    end else begin
      r_frame <= 1'b0;
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= w_idx_nxt;
        // pos and seg load together so a digit never shows another's glyph
        r_pos   <= DIGITS'(1) << w_idx_nxt;
        r_seg   <= w_dark ? 8'h00 : {dp[w_idx_nxt], w_glyph};
        r_frame <= (w_idx_nxt == c_idx_first);
        if (r_bcnt == c_blink_last) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt  <= r_bcnt + 1'b1;
        end
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  assign pos   = (POS_ACTIVE_LOW != 0) ? ~r_pos : r_pos;
  assign seg   = (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;
  assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_n.sv
`default_nettype none
// Bench for seg_scan_n: three instances (4-digit, 4-digit inverted polarity, 6-digit fast)
// driven by directed and random steps and checked against a tick-count reference model.
module tb_seg_scan_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] data_a;
  logic [3:0]  dp_a, blank_a, blink_a;
  logic [23:0] data_c;
  logic [5:0]  dp_c, blank_c, blink_c;

  logic [3:0]  pos_a, pos_b;
  logic [7:0]  seg_a, seg_b, seg_c;
  logic        frame_a, frame_b, frame_c;
  logic [5:0]  pos_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_scan_n #(.DIGITS(4), .SCAN_DIV(4), .BLINK_TICKS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data_a), .dp(dp_a),
    .blank(blank_a), .blink(blink_a), .pos(pos_a), .seg(seg_a), .frame(frame_a));

  seg_scan_n #(.DIGITS(4), .SCAN_DIV(4), .BLINK_TICKS(3),
               .SEG_ACTIVE_LOW(1), .POS_ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data_a), .dp(dp_a),
    .blank(blank_a), .blink(blink_a), .pos(pos_b), .seg(seg_b), .frame(frame_b));

  seg_scan_n #(.DIGITS(6), .SCAN_DIV(2), .BLINK_TICKS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .data(data_c), .dp(dp_c),
    .blank(blank_c), .blink(blink_c), .pos(pos_c), .seg(seg_c), .frame(frame_c));

  // Reference model: p = cycles into current slot, n = ticks since reset.
  typedef struct {
    int         p;
    int         n;
    logic [7:0] pos;
    logic [7:0] seg;
    logic       frame;
  } mstate_t;

  mstate_t ma, mc;

  function automatic logic [6:0] glyph(input int v);
    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h01, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40};
    return tbl[v];
  endfunction

  function automatic mstate_t mreset();
    mstate_t s;
    s.p = 0; s.n = 0; s.pos = 8'h00; s.seg = 8'h00; s.frame = 1'b0;
    return s;
  endfunction

  function automatic mstate_t mstep(input mstate_t s_in, input int d, input int sd, input int bt,
                                    input logic e, input logic [31:0] dat,
                                    input logic [7:0] dpv, input logic [7:0] blv, input logic [7:0] bkv);
    mstate_t s = s_in;
    int k, ph, v;
    if (!e) begin
      s.pos = 8'h00; s.seg = 8'h00; s.frame = 1'b0;
    end else if (s.p == sd - 1) begin
      s.p = 0;
      s.n = s.n + 1;
      k  = d - 1 - ((s.n - 1) % d);
      ph = ((s.n - 1) / bt) % 2;
      v  = int'((dat >> (4 * k)) & 32'hF);
      s.pos   = 8'(1 << k);
      s.frame = (k == d - 1);
      s.seg   = (blv[k] || (bkv[k] && ph == 1)) ? 8'h00 : {dpv[k], glyph(v)};
    end else begin
      s.p = s.p + 1;
      s.frame = 1'b0;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_pos",   {4'h0, pos_a},   ma.pos);
    chk("a_seg",   seg_a,           ma.seg);
    chk("a_frame", {7'h0, frame_a}, {7'h0, ma.frame});
    chk("b_pos",   {4'h0, pos_b},   {4'h0, ~ma.pos[3:0]});
    chk("b_seg",   seg_b,           ~ma.seg);
    chk("b_frame", {7'h0, frame_b}, {7'h0, ma.frame});
    chk("c_pos",   {2'h0, pos_c},   mc.pos);
    chk("c_seg",   seg_c,           mc.seg);
    chk("c_frame", {7'h0, frame_c}, {7'h0, mc.frame});
  endtask

  task automatic step();
    ma = mstep(ma, 4, 4, 3, en, {16'h0, data_a}, {4'h0, dp_a}, {4'h0, blank_a}, {4'h0, blink_a});
    mc = mstep(mc, 6, 2, 2, en, {8'h0, data_c}, {2'h0, dp_c}, {2'h0, blank_c}, {2'h0, blink_c});
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic randomize_inputs(input bit masks);
    data_a = 16'($urandom);
    dp_a   = 4'($urandom);
    data_c = 24'($urandom);
    dp_c   = 6'($urandom);
    if (masks) begin
      blank_a = 4'($urandom) & 4'($urandom);
      blink_a = 4'($urandom);
      blank_c = 6'($urandom) & 6'($urandom);
      blink_c = 6'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    data_a = 16'h3210; dp_a = '0; blank_a = '0; blink_a = '0;
    data_c = 24'h543210; dp_c = '0; blank_c = '0; blink_c = '0;
    ma = mreset(); mc = mreset();
    repeat (2) @(posedge clk);
    #1;
    check_all();

    // Basic scan order with fixed data
    rst_n = 1'b1; en = 1'b1;
    repeat (24) step();

    // Glyph sweep: every digit shows v, dp toggles with v
    for (int v = 0; v < 16; v++) begin
      data_a = {4{4'(v)}};
      data_c = {6{4'(v)}};
      dp_a   = (v % 2 == 0) ? 4'hF : 4'h0;
      dp_c   = (v % 2 == 0) ? 6'h3F : 6'h00;
      repeat (16) step();
    end

    // Blank digit 0, blink digit 1
    blank_a = 4'b0001; blink_a = 4'b0010;
    blank_c = 6'b000001; blink_c = 6'b000010;
    randomize_inputs(1'b0);
    repeat (60) step();

    // Data changes between ticks must not show until the next tick
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) randomize_inputs(1'b0);
      step();
    end

    // Enable drop and resume
    en = 1'b0;
    repeat (7) step();
    en = 1'b1;
    repeat (12) step();

    // Asynchronous reset in the middle of a slot
    repeat (2) step();
    rst_n = 1'b0;
    ma = mreset(); mc = mreset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Random soak
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) randomize_inputs($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) en = ~en;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
